// File: rtl/data_memory_stall.sv
`timescale 1ns/1ps
// Multi-cycle byte-addressable data memory for the MEM stage: req/resp handshake, LATENCY cycles per access,
// busy stalls the pipeline while an access is in flight; misaligned requests respond next cycle with no side effects.
module data_memory_stall #(
    parameter int          ADDR_W   = 8,
    parameter int          LATENCY  = 2,
    parameter int          INIT_IDX = 3,
    parameter logic [31:0] INIT_VAL = 32'd30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              misalign
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;
    logic                unsigned_q, unsigned_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                misalign_q, misalign_d;
    logic [31:0]         mem_q [DEPTH];
    logic [31:0]         mem_d [DEPTH];

    logic                req_misaligned;
    logic [ADDR_W-3:0]   idx;
    logic [31:0]         shifted;
    logic [31:0]         load_val;

    assign req_misaligned = (req_size == 2'b11)
                          || (req_size == 2'b01 && addr[0])
                          || (req_size == 2'b10 && addr[1:0] != 2'b00);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        mem_d      = mem_q;

        // Halves are 2-byte aligned, so the byte-lane shift also right-aligns them.
        idx     = addr_q[ADDR_W-1:2];
        shifted = mem_q[idx] >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   load_val = unsigned_q ? {24'b0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = unsigned_q ? {16'b0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = mem_q[idx];
        endcase

        case (state_q)
            IDLE, RESP: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    if (req_misaligned) begin
                        state_d    = RESP;
                        rdata_d    = '0;
                        misalign_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (write_q) begin
                        case (size_q)
                            2'b00:   mem_d[idx][{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
                            2'b01:   mem_d[idx][{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
                            default: mem_d[idx] = wdata_q;
                        endcase
                        rdata_d = '0;
                    end else begin
                        rdata_d = load_val;
                    end
                    misalign_d = 1'b0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == INIT_IDX) ? INIT_VAL : 32'd0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            mem_q      <= mem_d;
        end
    end

    assign busy       = (state_q == WAIT);
    assign resp_valid = (state_q == RESP);
    assign rdata      = rdata_q;
    assign misalign   = misalign_q;

endmodule
